// File: rtl/selectram_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : selectram_window_ctrl
// Purpose  : Configuration sequencer for the three-channel select-RAM group.
//            The host loads window bounds into shadow registers and issues a
//            commit. The bounds are validated, the block waits for any read
//            sweep to finish, copies the shadows to the active positions and
//            then holds position_gen_en so the select RAMs regenerate.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            cfg_wr_en/cfg_addr/cfg_data - shadow register write port
//            cfg_commit                  - single-cycle commit request
//            sweep_active                - group rd_en (read sweep running)
//            start_position_1..3,
//            end_position_1..3           - active window bounds
//            position_gen_en             - regeneration enable
//            position_3_error_sig        - channel 3 forced to 0 in last load
//            cfg_busy                    - sequencer not idle
//            cfg_err / cfg_overrun /
//            commit_done                 - one-cycle status pulses
// Revision : 1.0 - initial release
// ============================================================================
module selectram_window_ctrl #(
    parameter int GEN_CYCLES    = 256,  // 1..511
    parameter int SETTLE_CYCLES = 4     // 0..15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_wr_en,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic       cfg_commit,
    input  logic       sweep_active,
    output logic [7:0] start_position_1,
    output logic [7:0] end_position_1,
    output logic [7:0] start_position_2,
    output logic [7:0] end_position_2,
    output logic [7:0] start_position_3,
    output logic [7:0] end_position_3,
    output logic       position_gen_en,
    output logic       position_3_error_sig,
    output logic       cfg_busy,
    output logic       cfg_err,
    output logic       cfg_overrun,
    output logic       commit_done
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CHECK      = 3'd1,
        ST_WAIT_SWEEP = 3'd2,
        ST_LOAD       = 3'd3,
        ST_GEN        = 3'd4,
        ST_SETTLE     = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    // Down-counter reload values: the counter runs N-1 .. 0, i.e. N cycles.
    localparam logic [8:0] C_GEN_LOAD    = 9'(GEN_CYCLES - 1);
    localparam logic [8:0] C_SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 9'(SETTLE_CYCLES - 1) : 9'd0;

    state_t     r_state;
    logic [8:0] r_cnt;
    logic       r_ch3_bad;

    logic [7:0] r_sh_start1, r_sh_end1;
    logic [7:0] r_sh_start2, r_sh_end2;
    logic [7:0] r_sh_start3, r_sh_end3;

    // ------------------------------------------------------------------------
    // Shadow registers: writable in every state. A write in the same cycle as
    // a commit lands at that edge, so the CHECK cycle already sees it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_start1 <= 8'd0;
            r_sh_end1   <= 8'd0;
            r_sh_start2 <= 8'd0;
            r_sh_end2   <= 8'd0;
            r_sh_start3 <= 8'd0;
            r_sh_end3   <= 8'd0;
        end else if (cfg_wr_en) begin
            case (cfg_addr)
                3'd0:    r_sh_start1 <= cfg_data;
                3'd1:    r_sh_end1   <= cfg_data;
                3'd2:    r_sh_start2 <= cfg_data;
                3'd3:    r_sh_end2   <= cfg_data;
                3'd4:    r_sh_start3 <= cfg_data;
                3'd5:    r_sh_end3   <= cfg_data;
                default: ;  // addresses 6 and 7 are ignored
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer with registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state              <= ST_IDLE;
            r_cnt                <= 9'd0;
            r_ch3_bad            <= 1'b0;
            start_position_1     <= 8'd0;
            end_position_1       <= 8'd0;
            start_position_2     <= 8'd0;
            end_position_2       <= 8'd0;
            start_position_3     <= 8'd0;
            end_position_3       <= 8'd0;
            position_gen_en      <= 1'b0;
            position_3_error_sig <= 1'b0;
            cfg_err              <= 1'b0;
            cfg_overrun          <= 1'b0;
            commit_done          <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless re-asserted below.
            cfg_err     <= 1'b0;
            commit_done <= 1'b0;
            // A commit outside IDLE is dropped; only the overrun flag records it.
            cfg_overrun <= cfg_commit && (r_state != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (cfg_commit) begin
                        r_state <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if ((r_sh_start1 > r_sh_end1) || (r_sh_start2 > r_sh_end2)) begin
                        cfg_err <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        // A bad channel-3 window does not reject the commit;
                        // it only zeroes channel 3 at load time.
                        r_ch3_bad <= (r_sh_start3 > r_sh_end3);
                        r_state   <= ST_WAIT_SWEEP;
                    end
                end

                ST_WAIT_SWEEP: begin
                    if (!sweep_active) begin
                        r_state <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    start_position_1     <= r_sh_start1;
                    end_position_1       <= r_sh_end1;
                    start_position_2     <= r_sh_start2;
                    end_position_2       <= r_sh_end2;
                    start_position_3     <= r_ch3_bad ? 8'd0 : r_sh_start3;
                    end_position_3       <= r_ch3_bad ? 8'd0 : r_sh_end3;
                    position_3_error_sig <= r_ch3_bad;
                    position_gen_en      <= 1'b1;
                    r_cnt                <= C_GEN_LOAD;
                    r_state              <= ST_GEN;
                end

                ST_GEN: begin
                    if (r_cnt == 9'd0) begin
                        position_gen_en <= 1'b0;
                        if (SETTLE_CYCLES == 0) begin
                            commit_done <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_cnt   <= C_SETTLE_LOAD;
                            r_state <= ST_SETTLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 9'd1;
                    end
                end

                ST_SETTLE: begin
                    if (r_cnt == 9'd0) begin
                        commit_done <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 9'd1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_selectram_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_selectram_window_ctrl
// Purpose  : Self-checking bench for selectram_window_ctrl. A table of commit
//            vectors is driven; each commit pushes its expected outcome to a
//            queue, and a monitor pops and compares when the DUT reports
//            commit_done or cfg_err. Overrun and mid-generation reset are
//            exercised by dedicated sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_selectram_window_ctrl;

    localparam int GEN_CYCLES    = 256;
    localparam int SETTLE_CYCLES = 4;

    logic       clk;
    logic       rst_n;
    logic       cfg_wr_en;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic       cfg_commit;
    logic       sweep_active;
    logic [7:0] start_position_1, end_position_1;
    logic [7:0] start_position_2, end_position_2;
    logic [7:0] start_position_3, end_position_3;
    logic       position_gen_en;
    logic       position_3_error_sig;
    logic       cfg_busy;
    logic       cfg_err;
    logic       cfg_overrun;
    logic       commit_done;

    selectram_window_ctrl #(
        .GEN_CYCLES    (GEN_CYCLES),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cfg_wr_en            (cfg_wr_en),
        .cfg_addr             (cfg_addr),
        .cfg_data             (cfg_data),
        .cfg_commit           (cfg_commit),
        .sweep_active         (sweep_active),
        .start_position_1     (start_position_1),
        .end_position_1       (end_position_1),
        .start_position_2     (start_position_2),
        .end_position_2       (end_position_2),
        .start_position_3     (start_position_3),
        .end_position_3       (end_position_3),
        .position_gen_en      (position_gen_en),
        .position_3_error_sig (position_3_error_sig),
        .cfg_busy             (cfg_busy),
        .cfg_err              (cfg_err),
        .cfg_overrun          (cfg_overrun),
        .commit_done          (commit_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out (cycle %0d)", name, cyc);
    endtask

    // Stimulus record: bounds to write, sweep hold, and expected results.
    typedef struct packed {
        logic [7:0]  s1, e1, s2, e2, s3, e3;
        logic [31:0] hold;
        logic        exp_err;
        logic        exp_ch3;
        logic [47:0] exp_pos;
    } vec_t;

    // Scoreboard entry pushed at commit time.
    typedef struct {
        logic        err;
        logic        ch3;
        logic [47:0] pos;
        int          commit_cyc;
        int          first_gen;
    } exp_t;

    exp_t q[$];

    function automatic vec_t mk(input logic [7:0] s1, e1, s2, e2, s3, e3,
                                input int hold, input logic err, input logic ch3,
                                input logic [47:0] pos);
        vec_t v;
        v.s1 = s1; v.e1 = e1; v.s2 = s2; v.e2 = e2; v.s3 = s3; v.e3 = e3;
        v.hold = 32'(hold); v.exp_err = err; v.exp_ch3 = ch3; v.exp_pos = pos;
        return v;
    endfunction

    function automatic logic [47:0] all_pos();
        return {start_position_1, end_position_1, start_position_2,
                end_position_2, start_position_3, end_position_3};
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: counts generation / busy cycles, pops the scoreboard on every
    // completion event.
    // ------------------------------------------------------------------------
    int gen_cnt   = 0;
    int busy_cnt  = 0;
    int first_gen = -1;
    int last_gen  = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            gen_cnt   = 0;
            busy_cnt  = 0;
            first_gen = -1;
            last_gen  = -1;
        end else begin
            if (cfg_busy) busy_cnt++;
            if (position_gen_en) begin
                if (gen_cnt == 0) first_gen = cyc;
                last_gen = cyc;
                gen_cnt++;
            end
            if (commit_done || cfg_err) begin
                if (q.size() == 0) begin
                    check("unexpected_completion", {commit_done, cfg_err}, 2'b00);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("err_kind", {commit_done, cfg_err}, e.err ? 2'b01 : 2'b10);
                    check("positions", all_pos(), e.pos);
                    check("ch3_err_sig", position_3_error_sig, e.ch3);
                    if (e.err) begin
                        check("err_latency", cyc - e.commit_cyc, 2);
                        check("err_no_gen", gen_cnt, 0);
                        check("err_busy_cycles", busy_cnt, 1);
                    end else begin
                        check("gen_cycles", gen_cnt, GEN_CYCLES);
                        check("first_gen_cycle", first_gen, e.first_gen);
                        check("settle_to_done", cyc - last_gen, SETTLE_CYCLES + 1);
                        check("busy_cycles", busy_cnt, cyc - e.commit_cyc);
                    end
                end
                gen_cnt   = 0;
                busy_cnt  = 0;
                first_gen = -1;
                last_gen  = -1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver: write all six shadows (end3 together with the commit), optionally
    // hold sweep_active, optionally inject an overrun or an abort reset.
    // ------------------------------------------------------------------------
    task automatic run_commit(input vec_t v, input int ovr_at, input int abort_at);
        logic [7:0] vals [6];
        int n;
        exp_t e;
        vals[0] = v.s1; vals[1] = v.e1; vals[2] = v.s2;
        vals[3] = v.e2; vals[4] = v.s3; vals[5] = v.e3;
        for (int a = 0; a < 6; a++) begin
            @(negedge clk);
            cfg_wr_en = 1'b1;
            cfg_addr  = 3'(a);
            cfg_data  = vals[a];
            if (a == 5) begin
                cfg_commit = 1'b1;
                if (v.hold > 0) sweep_active = 1'b1;
                e.err        = v.exp_err;
                e.ch3        = v.exp_ch3;
                e.pos        = v.exp_pos;
                e.commit_cyc = cyc;
                e.first_gen  = (v.hold > 0) ? cyc + int'(v.hold) + 2 : cyc + 4;
                q.push_back(e);
            end
        end
        @(negedge clk);
        cfg_wr_en  = 1'b0;
        cfg_commit = 1'b0;
        if (v.hold > 0) begin
            repeat (int'(v.hold) - 1) @(negedge clk);
            sweep_active = 1'b0;
        end

        if (ovr_at > 0) begin
            n = 0;
            while (gen_cnt < ovr_at && n < 1000) begin @(negedge clk); n++; end
            if (n >= 1000) timeout_fail("overrun_wait");
            cfg_commit = 1'b1;
            @(negedge clk);
            cfg_commit = 1'b0;
            check("overrun_pulse", cfg_overrun, 1'b1);
            @(negedge clk);
            check("overrun_once", cfg_overrun, 1'b0);
        end

        if (abort_at > 0) begin
            n = 0;
            while (gen_cnt < abort_at && n < 1000) begin @(negedge clk); n++; end
            if (n >= 1000) timeout_fail("abort_wait");
            #2 rst_n = 1'b0;
            #1;
            check("async_reset_outputs",
                  {all_pos(), position_gen_en, position_3_error_sig, cfg_busy,
                   cfg_err, cfg_overrun, commit_done}, 54'd0);
            q.delete();
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check("idle_after_reset", {cfg_busy, position_gen_en}, 2'b00);
            return;
        end

        n = 0;
        while (q.size() > 0 && n < 3000) begin @(negedge clk); n++; end
        if (q.size() > 0) begin
            timeout_fail("completion_wait");
            q.delete();
        end
        @(negedge clk);
        check("idle_after_commit", cfg_busy, 1'b0);

        if (ovr_at > 0) begin
            repeat (20) @(negedge clk);
            check("no_second_gen", gen_cnt, 0);
            check("still_idle", cfg_busy, 1'b0);
        end
    endtask

    vec_t tbl [9];

    initial begin
        //           s1    e1    s2    e2    s3    e3   hold err ch3  expected active positions
        tbl[0] = mk(8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 0, 0, 0, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60});
        tbl[1] = mk(8'd10, 8'd20, 8'd90, 8'd80, 8'd50, 8'd60, 0, 1, 0, {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60});
        tbl[2] = mk(8'd10, 8'd20, 8'd30, 8'd40, 8'd200, 8'd100, 0, 0, 1, {8'd10, 8'd20, 8'd30, 8'd40, 8'd0, 8'd0});
        tbl[3] = mk(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 0, 0, 0, {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6});
        tbl[4] = mk(8'd0, 8'd255, 8'd255, 8'd255, 8'd7, 8'd7, 300, 0, 0, {8'd0, 8'd255, 8'd255, 8'd255, 8'd7, 8'd7});
        tbl[5] = mk(8'd5, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 0, 1, 0, {8'd0, 8'd255, 8'd255, 8'd255, 8'd7, 8'd7});
        tbl[6] = mk(8'd9, 8'd9, 8'd0, 8'd0, 8'd50, 8'd60, 0, 0, 0, {8'd9, 8'd9, 8'd0, 8'd0, 8'd50, 8'd60});
        // end3 written in the commit cycle turns channel 3 invalid (old end3=60 was valid)
        tbl[7] = mk(8'd9, 8'd9, 8'd0, 8'd0, 8'd50, 8'd40, 0, 0, 1, {8'd9, 8'd9, 8'd0, 8'd0, 8'd0, 8'd0});
        tbl[8] = mk(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 0, 0, 0, {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255});

        rst_n        = 1'b0;
        cfg_wr_en    = 1'b0;
        cfg_addr     = 3'd0;
        cfg_data     = 8'd0;
        cfg_commit   = 1'b0;
        sweep_active = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {all_pos(), position_gen_en, position_3_error_sig, cfg_busy,
               cfg_err, cfg_overrun, commit_done}, 54'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            run_commit(tbl[i], 0, 0);
        end

        // Second commit during generation: dropped, flagged once.
        run_commit(mk(8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66, 0, 0, 0,
                      {8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66}), 50, 0);

        // Reset at generation cycle 100, then a normal commit.
        run_commit(mk(8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 0, 0, 0,
                      {8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17}), 0, 100);
        run_commit(tbl[0], 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
